// File: rtl/link_protocol_if.sv
// rtl/link_protocol_if.sv - UART byte-FIFO handshake between the link codec and the RX/TX FIFOs
interface link_protocol_if;
  logic       rd_uart;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;

  modport master (output rd_uart, wr_uart, w_data, input r_data, rx_empty, tx_full);
  modport slave  (input rd_uart, wr_uart, w_data, output r_data, rx_empty, tx_full);
endinterface

// File: rtl/link_protocol.sv
// rtl/link_protocol.sv - framed direction/seed/heartbeat codec over UART byte FIFOs
// Queues TX requests as pending flags, reassembles RX frames and tracks peer liveness.
module link_protocol #(
  parameter int COORD_W        = 5,
  parameter int HB_PERIOD      = 1_000_000,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               singleplayer,
  input  logic               dir_send,
  input  logic [2:0]         dir_in,
  input  logic               seed_send,
  input  logic [COORD_W-1:0] seed_x_in,
  input  logic [COORD_W-1:0] seed_y_in,
  output logic [2:0]         dir_out,
  output logic               dir_valid,
  output logic [COORD_W-1:0] seed_x_out,
  output logic [COORD_W-1:0] seed_y_out,
  output logic               seed_valid,
  output logic               link_up,
  output logic               proto_err,
  link_protocol_if.master    uart
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] DIR_NONE = 3'd0;

  typedef enum logic [1:0] {RX_HDR, RX_SX, RX_SY} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SX, TX_SY} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [CW-1:0]      rx_silent, tx_idle;
  logic [COORD_W-1:0] rx_x;
  logic               rx_take, rx_timeout, dir_hit, seed_hit, err_hit, x_latch;

  logic               seed_pend, dir_pend, hb_pend;
  logic [COORD_W-1:0] seed_px, seed_py, tx_x, tx_y;
  logic [2:0]         dir_pd;
  logic               tx_ok, issue, take_seed, take_dir, take_hb, hb_fire;
  logic [7:0]         issue_byte;

  // Header bits [5:3] carry nothing; kept visible so the unused bits are explicit.
  logic unused_hdr;
  assign unused_hdr = ^uart.r_data;

  assign rx_take    = !uart.rx_empty && !uart.rd_uart;
  assign rx_timeout = !rx_take && (rx_silent == CW'(TIMEOUT_CYCLES - 1));
  assign tx_ok      = !uart.tx_full && !uart.wr_uart;
  assign hb_fire    = !uart.wr_uart && (tx_idle == CW'(HB_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_HDR;
      tx_state <= TX_IDLE;
    end else if (singleplayer) begin
      rx_state <= RX_HDR;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    dir_hit  = 1'b0;
    seed_hit = 1'b0;
    err_hit  = 1'b0;
    x_latch  = 1'b0;
    if (rx_take) begin
      case (rx_state)
        RX_HDR: begin
          case (uart.r_data[7:6])
            2'b00:   dir_hit = 1'b1;
            2'b01:   rx_next = RX_SX;
            2'b10:   ;
            default: err_hit = 1'b1;
          endcase
        end
        RX_SX: begin
          x_latch = 1'b1;
          rx_next = RX_SY;
        end
        RX_SY: begin
          seed_hit = 1'b1;
          rx_next  = RX_HDR;
        end
        default: rx_next = RX_HDR;
      endcase
    end else if (rx_timeout && rx_state != RX_HDR) begin
      // Peer went silent mid-seed: drop the partial frame.
      rx_next = RX_HDR;
      err_hit = 1'b1;
    end
  end

  always_comb begin
    tx_next    = tx_state;
    issue      = 1'b0;
    issue_byte = 8'h00;
    take_seed  = 1'b0;
    take_dir   = 1'b0;
    take_hb    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_ok) begin
          if (seed_pend) begin
            issue      = 1'b1;
            issue_byte = 8'h40;
            take_seed  = 1'b1;
            tx_next    = TX_SX;
          end else if (dir_pend) begin
            issue      = 1'b1;
            issue_byte = 8'(dir_pd);
            take_dir   = 1'b1;
          end else if (hb_pend) begin
            issue      = 1'b1;
            issue_byte = 8'h80;
            take_hb    = 1'b1;
          end
        end
      end
      TX_SX: begin
        if (tx_ok) begin
          issue      = 1'b1;
          issue_byte = 8'(tx_x);
          tx_next    = TX_SY;
        end
      end
      TX_SY: begin
        if (tx_ok) begin
          issue      = 1'b1;
          issue_byte = 8'(tx_y);
          tx_next    = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart.rd_uart <= 1'b0;
      dir_out      <= DIR_NONE;
      dir_valid    <= 1'b0;
      seed_x_out   <= '0;
      seed_y_out   <= '0;
      seed_valid   <= 1'b0;
      proto_err    <= 1'b0;
      link_up      <= 1'b0;
      rx_silent    <= '0;
      rx_x         <= '0;
    end else if (singleplayer) begin
      uart.rd_uart <= 1'b0;
      dir_out      <= DIR_NONE;
      dir_valid    <= 1'b0;
      seed_x_out   <= '0;
      seed_y_out   <= '0;
      seed_valid   <= 1'b0;
      proto_err    <= 1'b0;
      link_up      <= 1'b0;
      rx_silent    <= '0;
      rx_x         <= '0;
    end else begin
      uart.rd_uart <= rx_take;
      dir_valid    <= dir_hit;
      seed_valid   <= seed_hit;
      proto_err    <= err_hit;
      if (dir_hit) dir_out <= uart.r_data[2:0];
      if (x_latch) rx_x <= uart.r_data[COORD_W-1:0];
      if (seed_hit) begin
        seed_x_out <= rx_x;
        seed_y_out <= uart.r_data[COORD_W-1:0];
      end
      if (rx_take) begin
        rx_silent <= '0;
        link_up   <= 1'b1;
      end else if (rx_silent != CW'(TIMEOUT_CYCLES)) begin
        rx_silent <= rx_silent + 1'b1;
        if (rx_timeout) link_up <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart.wr_uart <= 1'b0;
      uart.w_data  <= 8'h00;
      seed_pend    <= 1'b0;
      dir_pend     <= 1'b0;
      hb_pend      <= 1'b0;
      seed_px      <= '0;
      seed_py      <= '0;
      dir_pd       <= DIR_NONE;
      tx_x         <= '0;
      tx_y         <= '0;
      tx_idle      <= '0;
    end else if (singleplayer) begin
      uart.wr_uart <= 1'b0;
      uart.w_data  <= 8'h00;
      seed_pend    <= 1'b0;
      dir_pend     <= 1'b0;
      hb_pend      <= 1'b0;
      seed_px      <= '0;
      seed_py      <= '0;
      dir_pd       <= DIR_NONE;
      tx_x         <= '0;
      tx_y         <= '0;
      tx_idle      <= '0;
    end else begin
      uart.wr_uart <= issue;
      if (issue) uart.w_data <= issue_byte;
      // A fresh request in the same cycle its flag is consumed queues a following message.
      if (seed_send) begin
        seed_pend <= 1'b1;
        seed_px   <= seed_x_in;
        seed_py   <= seed_y_in;
      end else if (take_seed) begin
        seed_pend <= 1'b0;
      end
      if (take_seed) begin
        tx_x <= seed_px;
        tx_y <= seed_py;
      end
      if (dir_send) begin
        dir_pend <= 1'b1;
        dir_pd   <= dir_in;
      end else if (take_dir) begin
        dir_pend <= 1'b0;
      end
      if (take_hb) hb_pend <= 1'b0;
      else if (hb_fire) hb_pend <= 1'b1;
      if (uart.wr_uart || hb_fire) tx_idle <= '0;
      else tx_idle <= tx_idle + 1'b1;
    end
  end
endmodule

// File: tb/tb_link_protocol.sv
// tb/tb_link_protocol.sv - randomized bench for link_protocol against a frame-level reference model
module tb_link_protocol;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          singleplayer = 1'b0;
  logic          dir_send = 1'b0;
  logic [2:0]    dir_in = 3'd0;
  logic          seed_send = 1'b0;
  logic [CW-1:0] seed_x_in = '0;
  logic [CW-1:0] seed_y_in = '0;
  logic [2:0]    dir_out;
  logic          dir_valid;
  logic [CW-1:0] seed_x_out, seed_y_out;
  logic          seed_valid, link_up, proto_err;

  link_protocol_if uart ();

  link_protocol #(.COORD_W(CW), .HB_PERIOD(20), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .singleplayer(singleplayer),
    .dir_send(dir_send), .dir_in(dir_in), .seed_send(seed_send),
    .seed_x_in(seed_x_in), .seed_y_in(seed_y_in),
    .dir_out(dir_out), .dir_valid(dir_valid),
    .seed_x_out(seed_x_out), .seed_y_out(seed_y_out), .seed_valid(seed_valid),
    .link_up(link_up), .proto_err(proto_err), .uart(uart)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_q[$];
  logic [2:0] got_dir[$], exp_dir[$];
  logic [9:0] got_seed[$], exp_seed[$];
  logic [7:0] got_tx[$], exp_tx[$];
  int         err_cnt = 0;
  int         rd_cnt = 0;
  logic       prev_rd = 1'b0, prev_wr = 1'b0, full_at_edge = 1'b0;

  initial begin
    uart.rx_empty = 1'b1;
    uart.r_data   = 8'h00;
  end

  always @(posedge clk) full_at_edge = uart.tx_full;

  // RX FIFO model plus output monitors, all on the falling edge.
  always @(negedge clk) begin
    chk("rd_back_to_back", {31'b0, uart.rd_uart & prev_rd}, 0);
    chk("wr_back_to_back", {31'b0, uart.wr_uart & prev_wr}, 0);
    if (uart.wr_uart) begin
      chk("wr_while_full", {31'b0, full_at_edge}, 0);
      got_tx.push_back(uart.w_data);
    end
    if (uart.rd_uart) begin
      rd_cnt++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (dir_valid) got_dir.push_back(dir_out);
    if (seed_valid) got_seed.push_back({seed_x_out, seed_y_out});
    if (proto_err) err_cnt++;
    prev_rd = uart.rd_uart;
    prev_wr = uart.wr_uart;
    uart.rx_empty = (rx_q.size() == 0);
    uart.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (rx_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("rx_drain", rx_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"}, {31'b0, uart.rd_uart}, 0);
    chk({tag, "_wr"}, {31'b0, uart.wr_uart}, 0);
    chk({tag, "_wdata"}, {24'b0, uart.w_data}, 0);
    chk({tag, "_dir"}, {29'b0, dir_out}, 0);
    chk({tag, "_seed"}, {22'b0, seed_x_out, seed_y_out}, 0);
    chk({tag, "_flags"}, {28'b0, dir_valid, seed_valid, link_up, proto_err}, 0);
  endtask

  task automatic rx_compare(input string tag);
    chk({tag, "_ndir"}, got_dir.size(), exp_dir.size());
    for (int i = 0; i < got_dir.size() && i < exp_dir.size(); i++)
      chk({tag, "_dir"}, {29'b0, got_dir[i]}, {29'b0, exp_dir[i]});
    chk({tag, "_nseed"}, got_seed.size(), exp_seed.size());
    for (int i = 0; i < got_seed.size() && i < exp_seed.size(); i++)
      chk({tag, "_seed"}, {22'b0, got_seed[i]}, {22'b0, exp_seed[i]});
    got_dir.delete(); exp_dir.delete(); got_seed.delete(); exp_seed.delete();
  endtask

  // Heartbeats may land between any two messages; strip them at frame boundaries.
  task automatic tx_compare(input string tag);
    logic [7:0] f[$];
    int i = 0;
    while (i < got_tx.size()) begin
      if (got_tx[i] == 8'h80) begin
        i++;
      end else if (got_tx[i][7:6] == 2'b01) begin
        for (int k = 0; k < 3; k++)
          if (i + k < got_tx.size()) f.push_back(got_tx[i + k]);
        i += 3;
      end else begin
        f.push_back(got_tx[i]);
        i++;
      end
    end
    chk({tag, "_nbytes"}, f.size(), exp_tx.size());
    for (int j = 0; j < f.size() && j < exp_tx.size(); j++)
      chk({tag, "_byte"}, {24'b0, f[j]}, {24'b0, exp_tx[j]});
    got_tx.delete(); exp_tx.delete();
  endtask

  initial begin
    int e0, n0, r0, t;
    logic [7:0] x8, y8;
    logic [2:0] d, ld;
    logic [1:0] sel;
    logic [CW-1:0] lx, ly, sx, sy;
    logic hold, have_s, have_d;

    uart.tx_full = 1'b0;
    tick(3);
    chk_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // Directed DIR then SEED frame.
    rx_q.push_back(8'h03); rx_q.push_back(8'h40); rx_q.push_back(8'h0A); rx_q.push_back(8'h15);
    exp_dir.push_back(3'd3); exp_seed.push_back({5'd10, 5'd21});
    drain(); tick(4);
    chk("rx1_link_up", {31'b0, link_up}, 1);
    chk("rx1_seed_x", {27'b0, seed_x_out}, 10);
    rx_compare("rx1");

    // Random RX frames against the frame-level model.
    e0 = err_cnt; t = 0;
    for (int m = 0; m < 40; m++) begin
      case ($urandom_range(0, 3))
        0: begin
          d = 3'($urandom_range(0, 7));
          rx_q.push_back({5'b0, d}); exp_dir.push_back(d);
        end
        1: begin
          x8 = 8'($urandom); y8 = 8'($urandom);
          rx_q.push_back(8'h40); rx_q.push_back(x8); rx_q.push_back(y8);
          exp_seed.push_back({x8[CW-1:0], y8[CW-1:0]});
        end
        2: rx_q.push_back(8'h80);
        default: begin
          rx_q.push_back(8'hC0 | 8'($urandom_range(0, 63))); t++;
        end
      endcase
      drain();
      tick($urandom_range(0, 8));
    end
    tick(4);
    rx_compare("rx_rand");
    chk("rx_rand_err", err_cnt - e0, t);

    // Timeout in the middle of a seed frame.
    rx_q.push_back(8'h40); rx_q.push_back(8'h05);
    drain(); tick(1);
    chk("to_link_before", {31'b0, link_up}, 1);
    e0 = err_cnt;
    tick(60);
    chk("to_err", err_cnt - e0, 1);
    chk("to_link_after", {31'b0, link_up}, 0);
    rx_q.push_back(8'h01); exp_dir.push_back(3'd1);
    drain(); tick(4);
    chk("to_relink", {31'b0, link_up}, 1);
    rx_compare("to");

    // Reserved opcode changes nothing but proto_err.
    e0 = err_cnt; d = dir_out; lx = seed_x_out;
    rx_q.push_back(8'hC0);
    drain(); tick(4);
    chk("rsv_err", err_cnt - e0, 1);
    chk("rsv_dir", {29'b0, dir_out}, {29'b0, d});
    chk("rsv_seed_x", {27'b0, seed_x_out}, {27'b0, lx});
    rx_compare("rsv");

    // Seed and dir requested together.
    got_tx.delete();
    seed_send = 1'b1; seed_x_in = 5'd7; seed_y_in = 5'd30; dir_send = 1'b1; dir_in = 3'd2;
    tick(1);
    seed_send = 1'b0; dir_send = 1'b0;
    exp_tx.push_back(8'h40); exp_tx.push_back(8'h07); exp_tx.push_back(8'h1E); exp_tx.push_back(8'h02);
    tick(20);
    tx_compare("tx_pair");

    // Held TX FIFO: latest dir wins, heartbeat follows.
    uart.tx_full = 1'b1;
    tick(2); got_tx.delete();
    dir_in = 3'd1; dir_send = 1'b1; tick(1); dir_send = 1'b0;
    tick(20);
    dir_in = 3'd4; dir_send = 1'b1; tick(1); dir_send = 1'b0;
    tick(76);
    chk("hold_quiet", got_tx.size(), 0);
    uart.tx_full = 1'b0;
    tick(15);
    chk("hold_n", got_tx.size(), 2);
    if (got_tx.size() >= 2) begin
      chk("hold_dir", {24'b0, got_tx[0]}, 32'h04);
      chk("hold_hb", {24'b0, got_tx[1]}, 32'h80);
    end
    got_tx.delete();

    // Random TX rounds with tx_full backpressure.
    for (int r = 0; r < 12; r++) begin
      hold = 1'($urandom_range(0, 1));
      have_s = 1'b0; have_d = 1'b0; lx = '0; ly = '0; ld = '0;
      uart.tx_full = hold;
      tick(2);
      for (int j = 0; j < (hold ? int'($urandom_range(1, 4)) : 1); j++) begin
        sel = 2'($urandom_range(1, 3));
        d = 3'($urandom_range(0, 7)); sx = CW'($urandom); sy = CW'($urandom);
        dir_send = sel[0]; seed_send = sel[1];
        dir_in = d; seed_x_in = sx; seed_y_in = sy;
        tick(1);
        dir_send = 1'b0; seed_send = 1'b0;
        if (sel[1]) begin have_s = 1'b1; lx = sx; ly = sy; end
        if (sel[0]) begin have_d = 1'b1; ld = d; end
        tick($urandom_range(0, 3));
      end
      if (have_s) begin
        exp_tx.push_back(8'h40); exp_tx.push_back(8'(lx)); exp_tx.push_back(8'(ly));
      end
      if (have_d) exp_tx.push_back(8'(ld));
      repeat (30) begin
        uart.tx_full = 1'($urandom_range(0, 1));
        tick(1);
      end
      uart.tx_full = 1'b0;
      tick(16);
      tx_compare("tx_rand");
    end

    // Asynchronous reset right after a seed header.
    tick(25); got_tx.delete();
    seed_send = 1'b1; seed_x_in = 5'd3; seed_y_in = 5'd4; tick(1); seed_send = 1'b0;
    t = 0;
    while (!(got_tx.size() > 0 && got_tx[got_tx.size() - 1] == 8'h40) && t < 20) begin
      tick(1); t++;
    end
    chk("rst_hdr_seen", {31'b0, t < 20}, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    tick(2);
    rst_n = 1'b1;
    n0 = got_tx.size();
    tick(10);
    chk("rst_no_resume", got_tx.size(), n0);

    // Singleplayer holds the block idle.
    singleplayer = 1'b1;
    tick(1);
    r0 = rd_cnt; n0 = got_tx.size();
    rx_q.push_back(8'h05);
    dir_in = 3'd6; dir_send = 1'b1; tick(1); dir_send = 1'b0;
    tick(20);
    chk("sp_no_rd", rd_cnt - r0, 0);
    chk("sp_rxq", rx_q.size(), 1);
    chk("sp_no_wr", got_tx.size(), n0);
    chk("sp_link", {31'b0, link_up}, 0);
    singleplayer = 1'b0;
    got_dir.delete();
    exp_dir.push_back(3'd5);
    drain(); tick(4);
    rx_compare("sp_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
